// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU-control decode plus registered ALU with optional
// iterative shift-add multiplier (enabled by macro ALU_EXEC_MUL_EN).
// Ports: clk_i, rst_i (sync, active-high), start_i, ALUop_i, funct_i,
//   src1_i, src2_i in; busy_o, done_o, result_o, zero_o, ALUctrl_o out.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       ALUop_i,
   input  logic [3:0]       funct_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic [3:0]       ALUctrl_o
);

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_XOR  = 4'b0011;
   localparam logic [3:0] C_SLL  = 4'b0100;
   localparam logic [3:0] C_SRL  = 4'b0101;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_SLT  = 4'b0111;
   localparam logic [3:0] C_SRA  = 4'b1000;
   localparam logic [3:0] C_NONE = 4'b1111;
`ifdef ALU_EXEC_MUL_EN
   localparam logic [3:0] C_MUL  = 4'b1001;
`endif

   logic [3:0]         ctrl_d;
   logic [WIDTH-1:0]   calc;
   logic [SHAMT_W-1:0] shamt;

   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;
   logic [3:0]         ctrl_q, ctrl_nx;

   assign shamt     = src2_i[SHAMT_W-1:0];
   assign result_o  = result_q;
   assign zero_o    = zero_q;
   assign done_o    = done_q;
   assign ALUctrl_o = ctrl_q;

   always_comb begin
      ctrl_d = C_NONE;
      unique case (ALUop_i)
         2'b00: ctrl_d = C_ADD;
         2'b01: ctrl_d = C_SUB;
         2'b11: ctrl_d = C_NONE;
         2'b10: begin
            unique case (funct_i)
               4'b0000: ctrl_d = C_ADD;
               4'b1000: ctrl_d = C_SUB;
               4'b0010: ctrl_d = C_SLT;
               4'b0110: ctrl_d = C_OR;
               4'b0111: ctrl_d = C_AND;
               4'b0100: ctrl_d = C_XOR;
               4'b0001: ctrl_d = C_SLL;
               4'b0101: ctrl_d = C_SRL;
               4'b1101: ctrl_d = C_SRA;
`ifdef ALU_EXEC_MUL_EN
               4'b1001: ctrl_d = C_MUL;
`endif
               default: ctrl_d = C_NONE;
            endcase
         end
      endcase
   end

   // Single-cycle datapath; MUL and NONE fall through to zero here.
   always_comb begin
      calc = '0;
      unique case (ctrl_d)
         C_ADD:   calc = src1_i + src2_i;
         C_SUB:   calc = src1_i - src2_i;
         C_SLT:   calc = {{(WIDTH-1){1'b0}},
                          ($signed(src1_i) < $signed(src2_i))};
         C_OR:    calc = src1_i | src2_i;
         C_AND:   calc = src1_i & src2_i;
         C_XOR:   calc = src1_i ^ src2_i;
         C_SLL:   calc = src1_i << shamt;
         C_SRL:   calc = src1_i >> shamt;
         C_SRA:   calc = WIDTH'($signed(src1_i) >>> shamt);
         default: calc = '0;
      endcase
   end

`ifdef ALU_EXEC_MUL_EN
   localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH);

   typedef enum logic {S_IDLE, S_MUL} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   acc_q, acc_d, acc_sum;
   logic [SHAMT_W:0]   count_q, count_d;

   assign busy_o  = (state_q == S_MUL);
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      result_d = result_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      ctrl_nx  = ctrl_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               ctrl_nx = ctrl_d;
               if (ctrl_d == C_MUL) begin
                  mcand_d  = src1_i;
                  mplier_d = src2_i;
                  acc_d    = '0;
                  count_d  = '0;
                  state_d  = S_MUL;
               end else begin
                  result_d = calc;
                  zero_d   = (calc == '0);
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            // Final iteration: commit this edge's sum directly.
            if (count_d == CNT_LAST) begin
               result_d = acc_sum;
               zero_d   = (acc_sum == '0);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end
`else
   assign busy_o = 1'b0;

   always_comb begin
      result_d = result_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      ctrl_nx  = ctrl_q;
      if (start_i) begin
         ctrl_nx  = ctrl_d;
         result_d = calc;
         zero_d   = (calc == '0);
         done_d   = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         ctrl_q   <= C_NONE;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         ctrl_q   <= ctrl_nx;
      end
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, clocked ALU execution unit for the multicycle CPU datapath. It merges ALU-control decode (ALUop/funct to ALU control code) with the arithmetic itself. Operands and operation are latched on a start handshake. Single-cycle operations complete on the next edge. An optional iterative shift-add multiplier takes WIDTH cycles and holds busy until done.

## Interface
- `WIDTH`, 32, datapath width; power of two, ≥ 8
- `SHAMT_W`, $clog2(WIDTH), shift-amount width (derived; do not override)

- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `start_i`  in  1  request; accepted only when `busy_o`=0
- `ALUop_i`  in  2  ALU opcode from main control
- `funct_i`  in  4  simplified function code {funct7 bit, funct3}
- `src1_i`  in  WIDTH  operand A
- `src2_i`  in  WIDTH  operand B / shift amount in [SHAMT_W-1:0]
- `busy_o`  out  1  multiply in progress
- `done_o`  out  1  one-cycle pulse: `result_o`/`zero_o` updated
- `result_o`  out  WIDTH  registered result, held until next `done_o`
- `zero_o`  out  1  registered (result == 0)
- `ALUctrl_o`  out  4  registered control code of the last accepted op

## Operation
- Decode, latched into `ALUctrl_o` on accept:
  - ALUop 00 → ADD 0010
  - ALUop 01 → SUB 0110
  - ALUop 11 → NONE 1111
  - ALUop 10 uses `funct_i`:
    - 0000 ADD 0010, 1000 SUB 0110
    - 0010 SLT 0111, 0110 OR 0001, 0111 AND 0000, 0100 XOR 0011
    - 0001 SLL 0100, 0101 SRL 0101, 1101 SRA 1000
    - 1001 MUL 1001
    - any other → NONE 1111
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare, giving 1 or 0 zero-extended.
  - Shifts use `src2_i[SHAMT_W-1:0]` only. SRA sign-fills.
  - MUL returns the low WIDTH bits of the unsigned product, which is also the correct low half for signed operands.
  - NONE gives result 0, so `zero_o`=1.
- FSM states: IDLE, MUL.
  - IDLE & `start_i` & non-MUL: compute from the inputs, load `result_o`/`zero_o`, pulse `done_o`, stay IDLE.
  - IDLE & `start_i` & MUL: load multiplicand=`src1_i`, multiplier=`src2_i`, acc=0, count=0; go to MUL.
  - MUL, each edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
  - MUL, on the edge where count reaches WIDTH: load `result_o` from the final acc, pulse `done_o`, return to IDLE.
  - `start_i` while in MUL is ignored. The operands are not captured and no error is raised.
- Reset, including mid-multiply: state IDLE; `busy_o`=0, `done_o`=0, `result_o`=0, `zero_o`=1, `ALUctrl_o`=1111, count=0. Any partial product is discarded.

## Timing
- Non-MUL op: `start_i` is sampled at edge E0. `done_o`=1 and the result are valid in the cycle after E0, so latency is 1.
- MUL op: accepted at E0. `busy_o`=1 for WIDTH cycles after E0. The final iteration at E_WIDTH raises `done_o` and the result, and drops `busy_o`.
- `done_o` is high for exactly one cycle per accepted op.
- A new `start_i` is accepted in the same cycle `done_o` is high, which gives full back-to-back throughput.
- Inputs need only be valid in the accept cycle.
- Outputs are registered only; there is no combinational input-to-output path.

## Configuration
- `ALU_EXEC_MUL_EN` defined: the MUL decode, the MUL state, the multiplier registers and `busy_o` behaviour are all present.
- Not defined:
  - funct 1001 decodes as NONE (1111, result 0, latency 1).
  - The MUL state and its registers are removed.
  - `busy_o` is tied to 0.

## Test plan
- Reset mid-multiply: assert `rst_i` 5 cycles into the MUL → next cycle `busy_o`=0, `result_o`=0, `zero_o`=1, `ALUctrl_o`=1111, no `done_o`.
- Single-cycle ops, WIDTH=32:
  - ADD 7+5 → 12.
  - SUB 5−5 → 0 with `zero_o`=1 and ALUctrl 0110.
  - SLT −1 vs 1 → 1.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - Each gives `done_o` one cycle after start.
- MUL 0x0001_0003 × 0x0000_0005 → 0x0005_000F. `busy_o` high 32 cycles, then `done_o`, with ALUctrl 1001.
- Start during busy: pulse `start_i` (ADD) 10 cycles into a MUL → ignored; only the MUL result appears.
- Back-to-back: XOR, OR, AND issued on consecutive cycles, each restarting in its `done_o` cycle → three consecutive `done_o` pulses with correct results.
- Undefined funct 0011 with ALUop 10 → result 0, ALUctrl 1111. Repeat with the macro undefined and funct 1001 → same response, `busy_o` never asserted.
